// File: rtl/iir_pkg.sv
// iir_pkg: fixed-point defaults and sample type shared by the pacer and the SOS stage
package iir_pkg;
  localparam int NDINT = 3;
  localparam int NDFRAC = 22;
  localparam int NGAP = 6;
  typedef logic signed [NDINT+NDFRAC-1:0] sample_t;
endpackage

// File: rtl/iir_sync_fifo.sv
// iir_sync_fifo: power-of-2 synchronous FIFO with wrap-bit pointers and empty pass-through
module iir_sync_fifo #(
  parameter int Width = 16,
  parameter int Depth = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(Depth);
  logic [Width-1:0] mem [Depth];
  logic [AW:0] wp, rp;
  logic do_wr, do_rd;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && (!empty || do_wr);
  assign rd_data = empty ? wr_data : mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_wr);
      rp <= rp + (AW+1)'(do_rd);
    end
endmodule

// File: rtl/iir_sample_pacer.sv
// iir_sample_pacer: buffers input samples and releases one converted sample per SOS schedule
// Define IIR_PACER_LEVEL_EN to add the registered occupancy port fill.
module iir_sample_pacer
  import iir_pkg::*;
#(
  parameter int Win = 16,
  parameter int Ndint = NDINT,
  parameter int Ndfrac = NDFRAC,
  parameter int Ngap = NGAP,
  parameter int Depth = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [Win-1:0]         s_data,
  output logic                   dv_out,
  output logic [Ndint+Ndfrac-1:0] d_out
`ifdef IIR_PACER_LEVEL_EN
  ,
  output logic [$clog2(Depth):0] fill
`endif
);
  localparam int W = Ndint + Ndfrac;
  localparam int SH = Ndfrac - (Win - 1);
  localparam int GW = (Ngap > 1) ? $clog2(Ngap) : 1;
  localparam int AW = $clog2(Depth);
  if (Ndfrac < Win - 1) begin : g_bad_frac
    $error("iir_sample_pacer: Ndfrac must be at least Win-1");
  end
  if (Ngap < 1) begin : g_bad_gap
    $error("iir_sample_pacer: Ngap must be at least 1");
  end
  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("iir_sample_pacer: Depth must be a power of 2");
  end
  logic [Win-1:0] rd_data;
  logic full, empty, wr, rd;
  logic [GW-1:0] gap;
  logic signed [W-1:0] cvt;
  assign s_ready = !reset && !full;
  assign wr = s_valid && s_ready;
  assign rd = !empty && gap == '0;
  // Sign-extend then shift: exact Q1.(Win-1) -> Q(Ndint).(Ndfrac), no rounding
  assign cvt = W'($signed(rd_data)) <<< SH;
  iir_sync_fifo #(.Width(Win), .Depth(Depth)) u_fifo (
    .clk(clk),
    .rst(reset),
    .wr_en(wr),
    .wr_data(s_data),
    .rd_en(rd),
    .rd_data(rd_data),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gap <= '0;
      dv_out <= 1'b0;
      d_out <= '0;
    end else begin
      dv_out <= rd;
      gap <= rd ? GW'(Ngap - 1) : gap - GW'(gap != '0);
      if (rd) d_out <= cvt;
    end
`ifdef IIR_PACER_LEVEL_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) fill <= '0;
    else fill <= fill + (AW+1)'(wr) - (AW+1)'(rd);
`endif
endmodule
